// File: rtl/ball_mover.sv
// Ball-motion engine for pong: advances a square ball on each end-of-frame
// move pulse, bounces it off the walls and the left paddle, detects misses,
// and keeps saturating hit/miss scores. Coordinates are registered outputs.
module ball_mover #(
    parameter int WIDTH        = 32,
    parameter int HEIGHT       = 16,
    parameter int SIZE         = 2,
    parameter int X_STEP       = 1,
    parameter int Y_STEP       = 1,
    parameter int START_X      = 16,
    parameter int START_Y      = 8,
    parameter int PADDLE_RIGHT = 1,
    parameter int SERVE_DELAY  = 2,
    localparam int xBits = $clog2(WIDTH + 1),
    localparam int yBits = $clog2(HEIGHT + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    move,
    input  logic signed [yBits:0]   paddleTop,
    input  logic signed [yBits:0]   paddleBottom,
    output logic signed [yBits:0]   top,
    output logic signed [yBits:0]   bottom,
    output logic signed [xBits:0]   left,
    output logic signed [xBits:0]   right,
    output logic                    hit,
    output logic                    miss,
    output logic                    playing,
    output logic [7:0]              hitCount,
    output logic [7:0]              missCount
);

    // Coordinates carry one extra sign bit so steps past an edge go negative
    // instead of wrapping.
    typedef logic signed [xBits:0] xc_t;
    typedef logic signed [yBits:0] yc_t;

    localparam int SC_W = (SERVE_DELAY > 0) ? $clog2(SERVE_DELAY + 1) : 1;
    typedef logic [SC_W-1:0] sc_t;

    localparam xc_t X_STEP_C = xc_t'(X_STEP);
    localparam yc_t Y_STEP_C = yc_t'(Y_STEP);
    localparam xc_t SIZE_X   = xc_t'(SIZE);
    localparam yc_t SIZE_Y   = yc_t'(SIZE);
    localparam xc_t X_LIMIT  = xc_t'(WIDTH - SIZE);
    localparam yc_t Y_LIMIT  = yc_t'(HEIGHT - SIZE);
    localparam yc_t Y_ZERO   = yc_t'(0);
    localparam xc_t PR_C     = xc_t'(PADDLE_RIGHT);
    localparam xc_t START_XC = xc_t'(START_X);
    localparam yc_t START_YC = yc_t'(START_Y);
    localparam sc_t SC_INIT  = sc_t'(SERVE_DELAY);

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        PLAY   = 2'd1,
        MISSED = 2'd2
    } state_t;

    state_t     state, state_n;
    sc_t        sc, sc_n;
    logic       dx, dx_n, dy, dy_n;
    xc_t        x_n, nx;
    yc_t        y_n, ny;
    logic [7:0] hc_n, mc_n;
    logic       hit_n, miss_n;
    logic       overlap;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign playing = (state == PLAY);

    // Next-state and next-position logic; everything holds unless move is high.
    always_comb begin
        state_n = state;
        sc_n    = sc;
        dx_n    = dx;
        dy_n    = dy;
        x_n     = left;
        y_n     = top;
        hc_n    = hitCount;
        mc_n    = missCount;
        hit_n   = 1'b0;
        miss_n  = 1'b0;
        nx      = dx ? (left + X_STEP_C) : (left - X_STEP_C);
        ny      = dy ? (top + Y_STEP_C) : (top - Y_STEP_C);
        overlap = (ny < paddleBottom) && ((ny + SIZE_Y) > paddleTop);
        if (move) begin
            case (state)
                SERVE: begin
                    if (sc == '0) state_n = PLAY;
                    else          sc_n    = sc - 1'b1;
                end
                PLAY: begin
                    if (ny <= Y_ZERO) begin
                        y_n  = Y_ZERO;
                        dy_n = 1'b1;
                    end else if (ny >= Y_LIMIT) begin
                        y_n  = Y_LIMIT;
                        dy_n = 1'b0;
                    end else begin
                        y_n = ny;
                    end
                    if (dx) begin
                        if (nx >= X_LIMIT) begin
                            x_n  = X_LIMIT;
                            dx_n = 1'b0;
                        end else begin
                            x_n = nx;
                        end
                    end else if (nx <= PR_C) begin
                        if (overlap) begin
                            x_n   = PR_C;
                            dx_n  = 1'b1;
                            hit_n = 1'b1;
                            hc_n  = sat_inc(hitCount);
                        end else begin
                            // Ball freezes where it slipped past the paddle.
                            x_n     = left;
                            y_n     = top;
                            dy_n    = dy;
                            miss_n  = 1'b1;
                            mc_n    = sat_inc(missCount);
                            state_n = MISSED;
                        end
                    end else begin
                        x_n = nx;
                    end
                end
                MISSED: begin
                    x_n     = START_XC;
                    y_n     = START_YC;
                    dx_n    = 1'b1;
                    sc_n    = SC_INIT;
                    state_n = SERVE;
                end
                default: state_n = SERVE;
            endcase
        end
    end

    // State register and registered box coordinates, pulses and scores.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SERVE;
            sc        <= SC_INIT;
            dx        <= 1'b1;
            dy        <= 1'b1;
            left      <= START_XC;
            right     <= START_XC + SIZE_X;
            top       <= START_YC;
            bottom    <= START_YC + SIZE_Y;
            hit       <= 1'b0;
            miss      <= 1'b0;
            hitCount  <= 8'd0;
            missCount <= 8'd0;
        end else begin
            state     <= state_n;
            sc        <= sc_n;
            dx        <= dx_n;
            dy        <= dy_n;
            left      <= x_n;
            right     <= x_n + SIZE_X;
            top       <= y_n;
            bottom    <= y_n + SIZE_Y;
            hit       <= hit_n;
            miss      <= miss_n;
            hitCount  <= hc_n;
            missCount <= mc_n;
        end
    end

endmodule

// File: tb/tb_ball_mover.sv
// Directed testbench for ball_mover with default parameters: a table of
// move-count records along one hand-traced trajectory, plus sequences for
// pulse width, reset-with-move, score saturation and idle hold.
module tb_ball_mover;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              move  = 1'b0;
    logic signed [5:0] paddleTop    = 6'sd0;
    logic signed [5:0] paddleBottom = 6'sd16;
    logic signed [5:0] top, bottom;
    logic signed [6:0] left, right;
    logic              hit, miss, playing;
    logic [7:0]        hitCount, missCount;

    int total = 0;
    int bad   = 0;
    int both  = 0;

    ball_mover dut (
        .clock        (clock),
        .reset        (reset),
        .move         (move),
        .paddleTop    (paddleTop),
        .paddleBottom (paddleBottom),
        .top          (top),
        .bottom       (bottom),
        .left         (left),
        .right        (right),
        .hit          (hit),
        .miss         (miss),
        .playing      (playing),
        .hitCount     (hitCount),
        .missCount    (missCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        int n;
        int pt;
        int pb;
        int l;
        int t;
        int pl;
        int h;
        int m;
        int hc;
        int mc;
    } vec_t;

    vec_t vecs[30];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int l, input int t, input int pl,
                           input int h, input int m, input int hc, input int mc);
        chk({nm, "_left"},   int'(left),   l);
        chk({nm, "_right"},  int'(right),  l + 2);
        chk({nm, "_top"},    int'(top),    t);
        chk({nm, "_bottom"}, int'(bottom), t + 2);
        chk({nm, "_play"},   int'(playing), pl);
        chk({nm, "_hit"},    int'(hit),    h);
        chk({nm, "_miss"},   int'(miss),   m);
        chk({nm, "_hc"},     int'(hitCount),  hc);
        chk({nm, "_mc"},     int'(missCount), mc);
    endtask

    // One move pulse per call; returns at the negedge after the update edge.
    task automatic do_moves(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            move = 1'b1;
            @(negedge clock);
            move = 1'b0;
        end
    endtask

    // Holds move high until the wanted pulse appears, bounded.
    task automatic run_until(input bit want_miss, output bit ok);
        ok = 1'b0;
        move = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clock);
            if (hit && miss) both++;
            if (want_miss ? miss : hit) ok = 1'b1;
        end
        move = 1'b0;
    endtask

    initial begin
        bit ok;
        int s_l, s_t, s_hc, s_mc, s_pl, pulses;

        //        n  pt  pb   l   t pl h m hc mc
        vecs[0]  = '{1,  0, 16, 16,  8, 0, 0, 0, 0, 0};
        vecs[1]  = '{1,  0, 16, 16,  8, 0, 0, 0, 0, 0};
        vecs[2]  = '{1,  0, 16, 16,  8, 1, 0, 0, 0, 0};
        vecs[3]  = '{1,  0, 16, 17,  9, 1, 0, 0, 0, 0};
        vecs[4]  = '{4,  0, 16, 21, 13, 1, 0, 0, 0, 0};
        vecs[5]  = '{1,  0, 16, 22, 14, 1, 0, 0, 0, 0};
        vecs[6]  = '{7,  0, 16, 29,  7, 1, 0, 0, 0, 0};
        vecs[7]  = '{1,  0, 16, 30,  6, 1, 0, 0, 0, 0};
        vecs[8]  = '{5,  0, 16, 25,  1, 1, 0, 0, 0, 0};
        vecs[9]  = '{1,  0, 16, 24,  0, 1, 0, 0, 0, 0};
        vecs[10] = '{13, 0, 16, 11, 13, 1, 0, 0, 0, 0};
        vecs[11] = '{1,  0, 16, 10, 14, 1, 0, 0, 0, 0};
        vecs[12] = '{8,  0, 16,  2,  6, 1, 0, 0, 0, 0};
        vecs[13] = '{1,  0, 16,  1,  5, 1, 1, 0, 1, 0};
        vecs[14] = '{4,  0, 16,  5,  1, 1, 0, 0, 1, 0};
        vecs[15] = '{1,  0, 16,  6,  0, 1, 0, 0, 1, 0};
        vecs[16] = '{13, 0, 16, 19, 13, 1, 0, 0, 1, 0};
        vecs[17] = '{1,  0, 16, 20, 14, 1, 0, 0, 1, 0};
        vecs[18] = '{9,  0, 16, 29,  5, 1, 0, 0, 1, 0};
        vecs[19] = '{1,  0, 16, 30,  4, 1, 0, 0, 1, 0};
        vecs[20] = '{3,  0, 16, 27,  1, 1, 0, 0, 1, 0};
        vecs[21] = '{1,  0, 16, 26,  0, 1, 0, 0, 1, 0};
        vecs[22] = '{13, 0, 16, 13, 13, 1, 0, 0, 1, 0};
        vecs[23] = '{1,  0, 16, 12, 14, 1, 0, 0, 1, 0};
        vecs[24] = '{10, 12, 16, 2,  4, 1, 0, 0, 1, 0};
        vecs[25] = '{1, 12, 16,  2,  4, 0, 0, 1, 1, 1};
        vecs[26] = '{1, 12, 16, 16,  8, 0, 0, 0, 1, 1};
        vecs[27] = '{2, 12, 16, 16,  8, 0, 0, 0, 1, 1};
        vecs[28] = '{1, 12, 16, 16,  8, 1, 0, 0, 1, 1};
        vecs[29] = '{1, 12, 16, 17,  7, 1, 0, 0, 1, 1};

        // Reset state
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk_all("reset", 16, 8, 0, 0, 0, 0, 0);

        // Hand-traced trajectory; record 13 is the paddle hit
        for (int i = 0; i < 30; i++) begin
            paddleTop    = 6'(vecs[i].pt);
            paddleBottom = 6'(vecs[i].pb);
            do_moves(vecs[i].n);
            chk_all($sformatf("vec%0d", i), vecs[i].l, vecs[i].t, vecs[i].pl,
                    vecs[i].h, vecs[i].m, vecs[i].hc, vecs[i].mc);
            if (i == 13 || i == 25) begin
                @(negedge clock);
                chk($sformatf("vec%0d_pulse_end_hit", i), int'(hit), 0);
                chk($sformatf("vec%0d_pulse_end_miss", i), int'(miss), 0);
                chk($sformatf("vec%0d_hold_left", i), int'(left), vecs[i].l);
            end
        end

        // Reset coincident with move mid-play
        @(negedge clock);
        reset = 1'b1;
        move  = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        move  = 1'b0;
        chk_all("rst_move", 16, 8, 0, 0, 0, 0, 0);

        // Miss-score saturation: paddle never overlaps
        paddleTop    = 6'sd0;
        paddleBottom = 6'sd0;
        for (int i = 0; i < 260; i++) begin
            run_until(1'b1, ok);
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL miss_wait: no miss within 200 moves at miss %0d", i);
                break;
            end
        end
        chk("miss_sat_mc", int'(missCount), 255);
        chk("miss_sat_hc", int'(hitCount), 0);

        // Hit-score saturation: paddle covers the full height
        paddleTop    = 6'sd0;
        paddleBottom = 6'sd16;
        for (int i = 0; i < 260; i++) begin
            run_until(1'b0, ok);
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL hit_wait: no hit within 200 moves at hit %0d", i);
                break;
            end
        end
        chk("hit_sat_hc", int'(hitCount), 255);
        chk("hit_sat_mc", int'(missCount), 255);
        chk("no_both_pulses", both, 0);

        // Idle: 1000 cycles without move change nothing
        @(negedge clock);
        s_l  = int'(left);
        s_t  = int'(top);
        s_pl = int'(playing);
        s_hc = int'(hitCount);
        s_mc = int'(missCount);
        pulses = 0;
        repeat (1000) begin
            @(negedge clock);
            if (hit || miss) pulses++;
        end
        chk("idle_left",   int'(left),   s_l);
        chk("idle_right",  int'(right),  s_l + 2);
        chk("idle_top",    int'(top),    s_t);
        chk("idle_bottom", int'(bottom), s_t + 2);
        chk("idle_play",   int'(playing), s_pl);
        chk("idle_hc",     int'(hitCount),  s_hc);
        chk("idle_mc",     int'(missCount), s_mc);
        chk("idle_pulses", pulses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
